// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order tracker for predicted conditional branches.
// Entries are allocated at the tail by IF and resolved out of order by tag from
// the ALU. The head is retired in order: it trains the predictor and, on a
// mispredict, flushes the whole queue and redirects IF to the correct pc.

`ifndef RAM_ADR_W
`define RAM_ADR_W 32
`endif

module branch_resolve_queue #(
    parameter int DEPTH_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  alloc_v_i,
    input  logic [`RAM_ADR_W-1:0] alloc_pc_i,
    input  logic [`RAM_ADR_W-1:0] alloc_tgt_i,
    input  logic                  alloc_pred_i,
    output logic [DEPTH_W-1:0]    alloc_tag_o,
    output logic                  full_o,
    input  logic                  res_v_i,
    input  logic [DEPTH_W-1:0]    res_tag_i,
    input  logic                  res_taken_i,
    output logic                  bp_en_o,
    output logic                  bp_abr_o,
    output logic [`RAM_ADR_W-1:0] bp_tpc_o,
    output logic                  flush_o,
    output logic [`RAM_ADR_W-1:0] flush_pc_o,
    output logic [DEPTH_W:0]      count_o
);

    localparam int N = 2 ** DEPTH_W;
    localparam int AW = `RAM_ADR_W;

    // Per-entry state
    logic [N-1:0]  valid_q, valid_d;
    logic [N-1:0]  resolved_q, resolved_d;
    logic [N-1:0]  taken_q, taken_d;
    logic [N-1:0]  pred_q, pred_d;
    logic [AW-1:0] pc_q  [N];
    logic [AW-1:0] pc_d  [N];
    logic [AW-1:0] tgt_q [N];
    logic [AW-1:0] tgt_d [N];

    // Queue pointers and registered feedback outputs
    logic [DEPTH_W-1:0] head_q, head_d;
    logic [DEPTH_W-1:0] tail_q, tail_d;
    logic [DEPTH_W:0]   count_q, count_d;
    logic               bp_en_q, bp_en_d;
    logic               bp_abr_q, bp_abr_d;
    logic [AW-1:0]      bp_tpc_q, bp_tpc_d;
    logic               flush_q, flush_d;
    logic [AW-1:0]      flush_pc_q, flush_pc_d;

    // Cycle-wide events; retire only looks at registered state so a resolve
    // landing on the head takes effect one edge later.
    logic do_alloc, do_res, do_retire, do_flush;

    assign full_o    = (count_q == (DEPTH_W+1)'(N));
    assign do_alloc  = en && alloc_v_i && !full_o;
    assign do_res    = en && res_v_i;
    assign do_retire = en && valid_q[head_q] && resolved_q[head_q];
    assign do_flush  = do_retire && (taken_q[head_q] != pred_q[head_q]);

    // Per-entry next state; flush overrides any alloc/resolve in the same cycle
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
        logic alloc_hit, res_hit, ret_hit;
        assign alloc_hit = do_alloc && (tail_q == DEPTH_W'(gi));
        assign res_hit   = do_res && (res_tag_i == DEPTH_W'(gi)) && valid_q[gi];
        assign ret_hit   = do_retire && (head_q == DEPTH_W'(gi));

        assign valid_d[gi]    = do_flush ? 1'b0 :
                                alloc_hit ? 1'b1 :
                                ret_hit ? 1'b0 : valid_q[gi];
        assign resolved_d[gi] = do_flush ? 1'b0 :
                                alloc_hit ? 1'b0 :
                                ret_hit ? 1'b0 :
                                res_hit ? 1'b1 : resolved_q[gi];
        assign taken_d[gi]    = res_hit ? res_taken_i : taken_q[gi];
        assign pred_d[gi]     = alloc_hit ? alloc_pred_i : pred_q[gi];
        assign pc_d[gi]       = alloc_hit ? alloc_pc_i : pc_q[gi];
        assign tgt_d[gi]      = alloc_hit ? alloc_tgt_i : tgt_q[gi];
    end

    // Pointer, occupancy and feedback next-state
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        bp_en_d    = 1'b0;
        bp_abr_d   = bp_abr_q;
        bp_tpc_d   = bp_tpc_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;
        if (do_retire) begin
            bp_en_d  = 1'b1;
            bp_abr_d = taken_q[head_q];
            bp_tpc_d = pc_q[head_q];
        end
        if (do_flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            flush_d    = 1'b1;
            flush_pc_d = taken_q[head_q] ? tgt_q[head_q] : (pc_q[head_q] + AW'(4));
        end else begin
            head_d  = head_q + DEPTH_W'(do_retire);
            tail_d  = tail_q + DEPTH_W'(do_alloc);
            count_d = count_q + (DEPTH_W+1)'(do_alloc) - (DEPTH_W+1)'(do_retire);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            resolved_q <= '0;
            taken_q    <= '0;
            pred_q     <= '0;
            for (int i = 0; i < N; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            bp_en_q    <= 1'b0;
            bp_abr_q   <= 1'b0;
            bp_tpc_q   <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            pred_q     <= pred_d;
            for (int i = 0; i < N; i++) begin
                pc_q[i]  <= pc_d[i];
                tgt_q[i] <= tgt_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            bp_en_q    <= bp_en_d;
            bp_abr_q   <= bp_abr_d;
            bp_tpc_q   <= bp_tpc_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    assign alloc_tag_o = tail_q;
    assign count_o     = count_q;
    assign bp_en_o     = bp_en_q;
    assign bp_abr_o    = bp_abr_q;
    assign bp_tpc_o    = bp_tpc_q;
    assign flush_o     = flush_q;
    assign flush_pc_o  = flush_pc_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue: linear steps, immediate assertions.

`ifndef RAM_ADR_W
`define RAM_ADR_W 32
`endif

module tb_branch_resolve_queue;

    localparam int DW = 3;
    localparam int AW = `RAM_ADR_W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b1;
    logic          alloc_v_i = 1'b0;
    logic [AW-1:0] alloc_pc_i = '0;
    logic [AW-1:0] alloc_tgt_i = '0;
    logic          alloc_pred_i = 1'b0;
    logic [DW-1:0] alloc_tag_o;
    logic          full_o;
    logic          res_v_i = 1'b0;
    logic [DW-1:0] res_tag_i = '0;
    logic          res_taken_i = 1'b0;
    logic          bp_en_o;
    logic          bp_abr_o;
    logic [AW-1:0] bp_tpc_o;
    logic          flush_o;
    logic [AW-1:0] flush_pc_o;
    logic [DW:0]   count_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    branch_resolve_queue #(.DEPTH_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .alloc_v_i(alloc_v_i), .alloc_pc_i(alloc_pc_i), .alloc_tgt_i(alloc_tgt_i),
        .alloc_pred_i(alloc_pred_i), .alloc_tag_o(alloc_tag_o), .full_o(full_o),
        .res_v_i(res_v_i), .res_tag_i(res_tag_i), .res_taken_i(res_taken_i),
        .bp_en_o(bp_en_o), .bp_abr_o(bp_abr_o), .bp_tpc_o(bp_tpc_o),
        .flush_o(flush_o), .flush_pc_o(flush_pc_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic alloc(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic pred);
        alloc_v_i = 1'b1; alloc_pc_i = pc; alloc_tgt_i = tgt; alloc_pred_i = pred;
    endtask

    task automatic resolve(input logic [DW-1:0] tag, input logic taken);
        res_v_i = 1'b1; res_tag_i = tag; res_taken_i = taken;
    endtask

    initial begin
        // 1: reset
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_count", AW'(count_o), 0);
        chk("rst_full", AW'(full_o), 0);
        chk("rst_tag", AW'(alloc_tag_o), 0);
        chk("rst_bp_en", AW'(bp_en_o), 0);
        chk("rst_flush", AW'(flush_o), 0);
        chk("rst_flush_pc", flush_pc_o, 0);

        // 2: correct prediction, one-cycle resolve-to-feedback latency
        alloc(32'h100, 32'h180, 1'b1);
        chk("c_tag", AW'(alloc_tag_o), 0);
        tick(); alloc_v_i = 1'b0;
        chk("c_count1", AW'(count_o), 1);
        resolve(0, 1'b1); tick(); res_v_i = 1'b0;
        chk("c_no_early_bp", AW'(bp_en_o), 0);
        tick();
        chk("c_bp_en", AW'(bp_en_o), 1);
        chk("c_abr", AW'(bp_abr_o), 1);
        chk("c_tpc", bp_tpc_o, 32'h100);
        chk("c_flush", AW'(flush_o), 0);
        chk("c_count0", AW'(count_o), 0);
        tick();
        chk("c_bp_pulse", AW'(bp_en_o), 0);

        // 3: mispredict; allocation on the retire edge is discarded
        alloc(32'h200, 32'h280, 1'b1);
        chk("m_tag", AW'(alloc_tag_o), 1);
        tick(); alloc_v_i = 1'b0;
        resolve(1, 1'b0); tick(); res_v_i = 1'b0;
        alloc(32'h300, 32'h380, 1'b0);
        tick(); alloc_v_i = 1'b0;
        chk("m_flush", AW'(flush_o), 1);
        chk("m_flush_pc", flush_pc_o, 32'h204);
        chk("m_abr", AW'(bp_abr_o), 0);
        chk("m_count", AW'(count_o), 0);
        chk("m_tag_reset", AW'(alloc_tag_o), 0);
        tick();
        chk("m_flush_pulse", AW'(flush_o), 0);
        chk("m_flush_pc_hold", flush_pc_o, 32'h204);

        // 4: out-of-order resolution, in-order retire
        for (int i = 0; i < 3; i++) begin
            alloc(AW'(32'h10 + 4 * i), 32'h0, 1'b0);
            tick();
        end
        alloc_v_i = 1'b0;
        chk("o_count3", AW'(count_o), 3);
        resolve(2, 1'b0); tick();
        resolve(0, 1'b0); tick();
        chk("o_no_retire_t2", AW'(bp_en_o), 0);
        resolve(1, 1'b0); tick(); res_v_i = 1'b0;
        chk("o_r0_en", AW'(bp_en_o), 1);
        chk("o_r0_tpc", bp_tpc_o, 32'h10);
        tick();
        chk("o_r1_en", AW'(bp_en_o), 1);
        chk("o_r1_tpc", bp_tpc_o, 32'h14);
        tick();
        chk("o_r2_en", AW'(bp_en_o), 1);
        chk("o_r2_tpc", bp_tpc_o, 32'h18);
        tick();
        chk("o_idle", AW'(bp_en_o), 0);
        chk("o_count0", AW'(count_o), 0);

        // 5: full, refused alloc, wrap, simultaneous alloc + retire
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            alloc(AW'(32'h1000 + 4 * i), 32'h0, 1'b0);
            tick();
        end
        chk("f_full", AW'(full_o), 1);
        chk("f_count8", AW'(count_o), 8);
        tick(); // 9th alloc while full
        alloc_v_i = 1'b0;
        chk("f_9th_dropped", AW'(count_o), 8);
        resolve(0, 1'b0); tick(); res_v_i = 1'b0;
        alloc(32'hDEAD0, 32'h0, 1'b0); // full now, refused despite retiring
        tick(); alloc_v_i = 1'b0;
        chk("f_ret_en", AW'(bp_en_o), 1);
        chk("f_ret_tpc", bp_tpc_o, 32'h1000);
        chk("f_count7", AW'(count_o), 7);
        chk("f_not_full", AW'(full_o), 0);
        chk("f_wrap_tag", AW'(alloc_tag_o), 0);
        alloc(32'h2000, 32'h0, 1'b0); tick(); alloc_v_i = 1'b0;
        chk("f_refull", AW'(full_o), 1);
        resolve(1, 1'b0); tick(); res_v_i = 1'b0;
        tick();
        chk("f_count7b", AW'(count_o), 7);
        resolve(2, 1'b0); tick(); res_v_i = 1'b0;
        alloc(32'h3000, 32'h0, 1'b0); tick(); alloc_v_i = 1'b0;
        chk("f_sim_en", AW'(bp_en_o), 1);
        chk("f_sim_tpc", bp_tpc_o, 32'h1008);
        chk("f_sim_count", AW'(count_o), 7);
        chk("f_sim_tag", AW'(alloc_tag_o), 2);

        // 5b: flush pc wrap and taken-mispredict target
        rst = 1'b1; tick(); rst = 1'b0;
        alloc(32'hFFFFFFFC, 32'h40, 1'b1); tick(); alloc_v_i = 1'b0;
        resolve(0, 1'b0); tick(); res_v_i = 1'b0;
        tick();
        chk("w_flush", AW'(flush_o), 1);
        chk("w_flush_pc", flush_pc_o, 32'h0);
        tick();
        alloc(32'h500, 32'h5A0, 1'b0); tick(); alloc_v_i = 1'b0;
        resolve(0, 1'b1); tick(); res_v_i = 1'b0;
        tick();
        chk("t_flush", AW'(flush_o), 1);
        chk("t_flush_pc", flush_pc_o, 32'h5A0);
        chk("t_abr", AW'(bp_abr_o), 1);
        tick();

        // 6: freeze with resolved head
        alloc(32'h600, 32'h0, 1'b0); tick(); alloc_v_i = 1'b0;
        resolve(0, 1'b0); tick(); res_v_i = 1'b0;
        en = 1'b0; tick();
        chk("z_frozen_en", AW'(bp_en_o), 0);
        tick();
        chk("z_frozen_count", AW'(count_o), 1);
        en = 1'b1; tick();
        chk("z_thaw_en", AW'(bp_en_o), 1);
        chk("z_thaw_tpc", bp_tpc_o, 32'h600);
        // resolve held across freeze is not lost
        alloc(32'h604, 32'h0, 1'b0); tick(); alloc_v_i = 1'b0;
        en = 1'b0; resolve(1, 1'b0); tick(); tick();
        chk("z_hold_en", AW'(bp_en_o), 0);
        en = 1'b1; tick(); res_v_i = 1'b0;
        tick();
        chk("z_held_en", AW'(bp_en_o), 1);
        chk("z_held_tpc", bp_tpc_o, 32'h604);
        // reset with 3 entries and a resolved head
        for (int i = 0; i < 3; i++) begin
            alloc(AW'(32'h700 + 4 * i), 32'h0, 1'b0);
            tick();
        end
        alloc_v_i = 1'b0;
        resolve(2, 1'b0); tick(); res_v_i = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("x_count", AW'(count_o), 0);
        chk("x_bp_en", AW'(bp_en_o), 0);
        tick();
        chk("x_bp_en2", AW'(bp_en_o), 0);
        chk("x_tag", AW'(alloc_tag_o), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
